// File: rtl/rewind_queue.sv
// Store-undo queue: records data replaced by each cache write, retires by ROB tag, replays unretired entries youngest-first on resteer.
// Latency: alloc/retire take effect next cycle; retired head frees one cycle after marking; first rewind entry the cycle after resteer.
// Backpressure: alloc dropped when full/stall/rewinding/resteer; rewind entry held until dealloc && !stall.
module rewind_queue #(
   parameter int OOO_TAG_SIZE = 10,
   parameter int DEPTH        = 8,
   parameter int RET_PORTS    = 2,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              stall,
   input  logic [RET_PORTS*OOO_TAG_SIZE-1:0] rob_ret_tag_in,
   input  logic [RET_PORTS-1:0]              rob_valid,
   input  logic                              rob_resteer,
   input  logic [ADDR_W-1:0]                 addr_in,
   input  logic [DATA_W-1:0]                 data_repl,
   input  logic [2:0]                        operation,
   input  logic [OOO_TAG_SIZE-1:0]           cache_ooo_tag_in,
   input  logic [1:0]                        size,
   input  logic                              alloc,
   input  logic                              dealloc,
   output logic                              valid_rewind,
   output logic [ADDR_W-1:0]                 addr_out,
   output logic [DATA_W-1:0]                 data_out,
   output logic [2:0]                        operation_out,
   output logic [OOO_TAG_SIZE-1:0]           cache_ooo_tag_out,
   output logic [1:0]                        size_out,
   output logic                              rewind_full,
   output logic                              rewind_empty,
   output logic                              rewind_busy,
   output logic [$clog2(DEPTH):0]            count
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

   typedef enum logic [1:0] {E_FREE, E_PEND, E_RET, E_FLUSH} est_t;
   typedef enum logic {S_IDLE, S_REWIND} fsm_t;

   typedef struct packed {
      logic [ADDR_W-1:0]       addr;
      logic [DATA_W-1:0]       data;
      logic [2:0]              op;
      logic [OOO_TAG_SIZE-1:0] tag;
      logic [1:0]              sz;
   } ent_t;

   est_t          st_q  [DEPTH];
   est_t          st_d  [DEPTH];
   ent_t          ent_q [DEPTH];
   ent_t          ent_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   fsm_t          fsm_q, fsm_d;

   logic [IW-1:0] head_idx;
   logic [IW-1:0] tail_idx;
   logic [IW-1:0] top_idx;
   logic          top_flush;
   logic          alloc_ok;
   logic          pop_ok;
   logic          drain_ok;

   // Pointer-derived status and the entry currently offered for rewind (youngest, at tail-1).
   always_comb begin
      head_idx     = head_q[IW-1:0];
      tail_idx     = tail_q[IW-1:0];
      top_idx      = tail_idx - IW'(1);
      count        = tail_q - head_q;
      rewind_full  = (count == FULL_CNT);
      rewind_empty = (count == '0);
      rewind_busy  = (fsm_q == S_REWIND);
      top_flush    = rewind_busy && !rewind_empty && (st_q[top_idx] == E_FLUSH);
      alloc_ok     = alloc && !rewind_full && !stall && (fsm_q == S_IDLE) && !rob_resteer;
      pop_ok       = top_flush && dealloc && !stall;
      // FREE entries are never RET, so an empty queue cannot drain.
      drain_ok     = (st_q[head_idx] == E_RET);
   end

   // Rewind output fields, forced to zero whenever no flushed entry is offered.
   always_comb begin
      valid_rewind      = top_flush;
      addr_out          = '0;
      data_out          = '0;
      operation_out     = '0;
      cache_ooo_tag_out = '0;
      size_out          = '0;
      if (top_flush) begin
         addr_out          = ent_q[top_idx].addr;
         data_out          = ent_q[top_idx].data;
         operation_out     = ent_q[top_idx].op;
         cache_ooo_tag_out = ent_q[top_idx].tag;
         size_out          = ent_q[top_idx].sz;
      end
   end

   // Next-state: retire marking, resteer flush, head drain, tail pop and alloc.
   always_comb begin
      st_d   = st_q;
      ent_d  = ent_q;
      head_d = head_q;
      tail_d = tail_q;
      fsm_d  = fsm_q;

      // Only entries already PEND at cycle start can be matched; the entry being
      // allocated this cycle is still FREE in st_q.
      for (int i = 0; i < DEPTH; i++) begin
         for (int p = 0; p < RET_PORTS; p++) begin
            if ((st_q[i] == E_PEND) && rob_valid[p] &&
                (ent_q[i].tag == rob_ret_tag_in[p*OOO_TAG_SIZE +: OOO_TAG_SIZE])) begin
               st_d[i] = E_RET;
            end
         end
      end

      if (rob_resteer) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (st_d[i] == E_PEND) begin
               st_d[i] = E_FLUSH;
            end
         end
         fsm_d = S_REWIND;
      end else if ((fsm_q == S_REWIND) && !top_flush) begin
         fsm_d = S_IDLE;
      end

      // Drain targets a RET entry and pop a FLUSH entry, so they never collide.
      if (drain_ok) begin
         st_d[head_idx] = E_FREE;
         head_d         = head_q + PW'(1);
      end

      if (pop_ok) begin
         st_d[top_idx] = E_FREE;
         tail_d        = tail_q - PW'(1);
      end

      // Alloc needs IDLE and pop needs REWIND, so tail moves at most one way.
      if (alloc_ok) begin
         st_d[tail_idx]      = E_PEND;
         ent_d[tail_idx].addr = addr_in;
         ent_d[tail_idx].data = data_repl;
         ent_d[tail_idx].op   = operation;
         ent_d[tail_idx].tag  = cache_ooo_tag_in;
         ent_d[tail_idx].sz   = size;
         tail_d              = tail_q + PW'(1);
      end
   end

   // State register with synchronous reset; reset also aborts a rewind in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            st_q[i]  <= E_FREE;
            ent_q[i] <= '0;
         end
         head_q <= '0;
         tail_q <= '0;
         fsm_q  <= S_IDLE;
      end else begin
         st_q   <= st_d;
         ent_q  <= ent_d;
         head_q <= head_d;
         tail_q <= tail_d;
         fsm_q  <= fsm_d;
      end
   end

endmodule

// File: tb/tb_rewind_queue.sv
// Bench for rewind_queue: queue-based reference model checked every cycle, plus directed scenarios with literal expectations.
// Model updates on posedge from the same inputs the DUT sees; comparisons run on negedge.
// Stimulus is driven 1ns after posedge; randomized phase follows the directed scenarios.
module tb_rewind_queue;

   localparam int T  = 10;
   localparam int D  = 8;
   localparam int RP = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   localparam int MS_PEND  = 1;
   localparam int MS_RET   = 2;
   localparam int MS_FLUSH = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            stall;
   logic [RP*T-1:0] rob_ret_tag_in;
   logic [RP-1:0]   rob_valid;
   logic            rob_resteer;
   logic [AW-1:0]   addr_in;
   logic [DW-1:0]   data_repl;
   logic [2:0]      operation;
   logic [T-1:0]    cache_ooo_tag_in;
   logic [1:0]      size;
   logic            alloc;
   logic            dealloc;
   logic            valid_rewind;
   logic [AW-1:0]   addr_out;
   logic [DW-1:0]   data_out;
   logic [2:0]      operation_out;
   logic [T-1:0]    cache_ooo_tag_out;
   logic [1:0]      size_out;
   logic            rewind_full;
   logic            rewind_empty;
   logic            rewind_busy;
   logic [3:0]      count;

   int  nchk = 0;
   int  nerr = 0;
   bit  chk_en = 1'b0;

   always #5 clk = ~clk;

   rewind_queue #(.OOO_TAG_SIZE(T), .DEPTH(D), .RET_PORTS(RP), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .rob_ret_tag_in(rob_ret_tag_in), .rob_valid(rob_valid),
      .rob_resteer(rob_resteer), .addr_in(addr_in), .data_repl(data_repl), .operation(operation),
      .cache_ooo_tag_in(cache_ooo_tag_in), .size(size), .alloc(alloc), .dealloc(dealloc),
      .valid_rewind(valid_rewind), .addr_out(addr_out), .data_out(data_out),
      .operation_out(operation_out), .cache_ooo_tag_out(cache_ooo_tag_out), .size_out(size_out),
      .rewind_full(rewind_full), .rewind_empty(rewind_empty), .rewind_busy(rewind_busy), .count(count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: ordered list head..tail ----------------
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [2:0]    op;
      logic [T-1:0]  tag;
      logic [1:0]    sz;
      int            st;
   } ment_t;

   ment_t mq[$];
   bit    m_busy = 1'b0;

   task automatic model_step();
      int    n;
      bit    v, do_pop, do_drain, do_alloc;
      ment_t e;
      if (rst) begin
         mq.delete();
         m_busy = 1'b0;
         return;
      end
      n        = mq.size();
      v        = m_busy && n > 0 && mq[n-1].st == MS_FLUSH;
      do_pop   = v && dealloc && !stall;
      do_drain = n > 0 && mq[0].st == MS_RET;
      do_alloc = alloc && n < D && !stall && !m_busy && !rob_resteer;
      for (int i = 0; i < n; i++) begin
         if (mq[i].st == MS_PEND) begin
            for (int p = 0; p < RP; p++) begin
               if (rob_valid[p] && mq[i].tag == rob_ret_tag_in[p*T +: T]) mq[i].st = MS_RET;
            end
         end
      end
      if (rob_resteer) begin
         for (int i = 0; i < n; i++) if (mq[i].st == MS_PEND) mq[i].st = MS_FLUSH;
         m_busy = 1'b1;
      end else if (m_busy && !v) begin
         m_busy = 1'b0;
      end
      if (do_pop) void'(mq.pop_back());
      if (do_drain) void'(mq.pop_front());
      if (do_alloc) begin
         e.addr = addr_in; e.data = data_repl; e.op = operation;
         e.tag = cache_ooo_tag_in; e.sz = size; e.st = MS_PEND;
         mq.push_back(e);
      end
   endtask

   always @(posedge clk) model_step();

   // Compare every DUT output against the model in the middle of each cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         bit v;
         n = mq.size();
         v = m_busy && n > 0 && mq[n-1].st == MS_FLUSH;
         chk("m_count", count, n);
         chk("m_full", rewind_full, (n == D));
         chk("m_empty", rewind_empty, (n == 0));
         chk("m_busy", rewind_busy, m_busy);
         chk("m_valid", valid_rewind, v);
         chk("m_addr", addr_out, v ? mq[n-1].addr : '0);
         chk("m_data", data_out, v ? mq[n-1].data : '0);
         chk("m_op", operation_out, v ? mq[n-1].op : '0);
         chk("m_tag", cache_ooo_tag_out, v ? mq[n-1].tag : '0);
         chk("m_size", size_out, v ? mq[n-1].sz : '0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      rst = 0; stall = 0; rob_valid = '0; rob_resteer = 0; alloc = 0; dealloc = 0;
   endtask

   task automatic put(input logic [T-1:0] tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
      alloc = 1; cache_ooo_tag_in = tag; addr_in = a; data_repl = d;
      operation = 3'(tag); size = 2'(tag);
      tick();
      alloc = 0;
   endtask

   task automatic retire(input logic [RP-1:0] v, input logic [T-1:0] t0, input logic [T-1:0] t1);
      rob_valid = v; rob_ret_tag_in = {t1, t0};
      tick();
      rob_valid = '0;
   endtask

   task automatic wait_idle();
      int k;
      dealloc = 1;
      for (k = 0; k < 40 && rewind_busy; k++) tick();
      dealloc = 0;
      chk("idle_timeout", rewind_busy, 1'b0);
   endtask

   logic [AW-1:0] sav_a [3];
   logic [DW-1:0] sav_d [3];

   initial begin
      idle_in();
      rst = 1; rob_ret_tag_in = '0; addr_in = '0; data_repl = '0;
      operation = '0; cache_ooo_tag_in = '0; size = '0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 0;
      chk("rst_count", count, 0);
      chk("rst_empty", rewind_empty, 1);
      chk("rst_full", rewind_full, 0);
      chk("rst_busy", rewind_busy, 0);
      chk("rst_valid", valid_rewind, 0);
      chk("rst_addr", addr_out, 0);

      // 1: dual-port retire, head drains one per cycle
      put(5, 32'h50, 32'h5000); put(6, 32'h60, 32'h6000); put(7, 32'h70, 32'h7000);
      chk("t1_cnt3", count, 3);
      retire(2'b11, 5, 6);
      chk("t1_cnt3b", count, 3);
      tick(); chk("t1_cnt2", count, 2);
      tick(); chk("t1_cnt1", count, 1);
      rob_resteer = 1; tick(); rob_resteer = 0;
      chk("t1_valid", valid_rewind, 1);
      chk("t1_head7", cache_ooo_tag_out, 7);
      chk("t1_addr", addr_out, 32'h70);
      wait_idle();
      chk("t1_cnt0", count, 0);

      // 2: rewind youngest-first while retired head drains
      for (int i = 1; i <= 4; i++) put(T'(i), 32'h100 + 32'(4*(i-1)), 32'hD000_0000 | 32'(i));
      retire(2'b01, 1, 0);
      rob_resteer = 1; tick(); rob_resteer = 0;
      dealloc = 1;
      chk("t2_v4", valid_rewind, 1);
      chk("t2_tag4", cache_ooo_tag_out, 4);
      chk("t2_addr4", addr_out, 32'h10C);
      chk("t2_cnt3", count, 3);
      tick();
      chk("t2_tag3", cache_ooo_tag_out, 3);
      chk("t2_addr3", addr_out, 32'h108);
      tick();
      chk("t2_tag2", cache_ooo_tag_out, 2);
      chk("t2_data2", data_out, 32'hD000_0002);
      tick();
      chk("t2_vend", valid_rewind, 0);
      chk("t2_cnt0", count, 0);
      wait_idle();

      // 3: ninth alloc dropped
      for (int i = 0; i < 9; i++) put(T'(20 + i), 32'h200 + 32'(i), 32'(i));
      chk("t3_full", rewind_full, 1);
      chk("t3_cnt8", count, 8);

      // 4: stall holds the rewind entry
      rob_resteer = 1; tick(); rob_resteer = 0;
      chk("t4_tag27", cache_ooo_tag_out, 27);
      dealloc = 1; stall = 1;
      tick();
      chk("t4_hold1", cache_ooo_tag_out, 27);
      chk("t4_cnt1", count, 8);
      tick();
      chk("t4_hold2", cache_ooo_tag_out, 27);
      chk("t4_v2", valid_rewind, 1);
      stall = 0;
      tick();
      chk("t4_tag26", cache_ooo_tag_out, 26);
      chk("t4_cnt7", count, 7);

      // 5: reset mid-rewind
      rst = 1; tick(); rst = 0; dealloc = 0;
      chk("t5_empty", rewind_empty, 1);
      chk("t5_busy", rewind_busy, 0);
      chk("t5_valid", valid_rewind, 0);
      chk("t5_addr", addr_out, 0);
      chk("t5_tag", cache_ooo_tag_out, 0);

      // 6: advance pointers so the three pending allocs straddle the index wrap
      for (int k = 0; k < 22; k++) begin
         put(T'(100 + k), $urandom, $urandom);
         retire(2'b01, T'(100 + k), 0);
      end
      for (int j = 0; j < 3; j++) begin
         sav_a[j] = $urandom; sav_d[j] = $urandom;
         put(T'(200 + j), sav_a[j], sav_d[j]);
      end
      chk("t6_cnt3", count, 3);
      rob_resteer = 1; tick(); rob_resteer = 0;
      dealloc = 1;
      for (int j = 2; j >= 0; j--) begin
         chk("t6_valid", valid_rewind, 1);
         chk("t6_tag", cache_ooo_tag_out, T'(200 + j));
         chk("t6_addr", addr_out, sav_a[j]);
         chk("t6_data", data_out, sav_d[j]);
         tick();
      end
      wait_idle();

      // Randomized phase against the model
      for (int c = 0; c < 4000; c++) begin
         alloc            = ($urandom_range(0, 99) < 55);
         cache_ooo_tag_in = T'($urandom_range(0, 15));
         addr_in          = $urandom;
         data_repl        = $urandom;
         operation        = 3'($urandom_range(0, 7));
         size             = 2'($urandom_range(0, 3));
         rob_valid        = RP'($urandom_range(0, 3));
         rob_ret_tag_in   = {T'($urandom_range(0, 15)), T'($urandom_range(0, 15))};
         rob_resteer      = ($urandom_range(0, 99) < 3);
         dealloc          = ($urandom_range(0, 99) < 75);
         stall            = ($urandom_range(0, 99) < 15);
         rst              = ($urandom_range(0, 999) < 3);
         tick();
      end
      idle_in();
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
